// File: rtl/sum_readout_pkg.sv
// Shared constants, FSM encoding and address helper for the sum readout path.
// The RAM layout is slot-major, point-minor.
package sum_readout_pkg;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 15;
    localparam int SLOTS   = 10;
    localparam int SLOT_W  = 4;
    localparam int POINT_W = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 9*2047+2046 = 20469 fits in 15 bits, so the sum never wraps.
    function automatic logic [ADDR_W-1:0] slot_addr(
        input logic [SLOT_W-1:0]  slot,
        input logic [POINT_W-1:0] point,
        input logic [POINT_W-1:0] points
    );
        return ADDR_W'(point) + ADDR_W'(slot) * ADDR_W'(points);
    endfunction

endpackage

// File: rtl/sum_fifo.sv
// Small synchronous FIFO buffering returned sums with their slot/point tags.
// Output is the head entry; count/empty/full are registered-state derived.
module sum_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        empty    = (count == '0);
        full     = (count == CNT_W'(DEPTH));
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        pop_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sum_readout.sv
// Streams a run of stored sums out of the sum RAM, tagging each with slot/point.
// Reads are throttled so every word returning from the RAM has a FIFO seat.
module sum_readout
    import sum_readout_pkg::*;
#(
    parameter int RAM_LAT = 2,
    parameter int FIFO_D  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [SLOT_W-1:0]  slot_first,
    input  logic [SLOT_W-1:0]  slot_count,
    input  logic [POINT_W-1:0] points,
    output logic [ADDR_W-1:0]  rd_address,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  ram_q,
    output logic [DATA_W-1:0]  out_data,
    output logic [SLOT_W-1:0]  out_slot,
    output logic [POINT_W-1:0] out_point,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    output logic               err
);
    localparam int ENTRY_W = DATA_W + SLOT_W + POINT_W;
    localparam int CNT_W   = $clog2(FIFO_D + 1);
    localparam int SUM_W   = SLOT_W + 1;

    state_t             state;
    logic [SLOT_W-1:0]  cfg_first;
    logic [SLOT_W-1:0]  cfg_count;
    logic [POINT_W-1:0] cfg_points;
    logic [SLOT_W-1:0]  slot_rel;
    logic [POINT_W-1:0] point_cnt;
    logic [SLOT_W-1:0]  rd_slot;
    logic [POINT_W-1:0] rd_point;

    logic [RAM_LAT-1:0] pipe_v;
    logic [SLOT_W-1:0]  pipe_slot  [RAM_LAT];
    logic [POINT_W-1:0] pipe_point [RAM_LAT];

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_in;
    logic [ENTRY_W-1:0] fifo_head;

    logic               cfg_ok;
    logic               issue;
    logic               last_point;
    logic               last_read;
    logic               drained;
    logic [SLOT_W-1:0]  slot_abs;
    int                 occ;

    always_comb begin
        cfg_ok = (points != '0) && (slot_count != '0) &&
                 ({1'b0, slot_first} + {1'b0, slot_count} <= SUM_W'(SLOTS));
        slot_abs   = cfg_first + slot_rel;
        last_point = (point_cnt == cfg_points - POINT_W'(1));
        last_read  = last_point && (slot_rel == cfg_count - SLOT_W'(1));

        fifo_pop  = !fifo_empty && out_ready;
        fifo_push = pipe_v[RAM_LAT-1];
        fifo_in   = {ram_q, pipe_slot[RAM_LAT-1], pipe_point[RAM_LAT-1]};

        // Words already owed to the FIFO: buffered, in the RAM pipe, or issued this cycle.
        occ = int'(fifo_count) + int'(rd_en) - int'(fifo_pop);
        for (int i = 0; i < RAM_LAT; i++) begin
            occ = occ + int'(pipe_v[i]);
        end
        issue = (state == READ) && !fifo_full && (occ < FIFO_D);

        drained = !rd_en && (pipe_v == '0) &&
                  (fifo_empty || (fifo_count == CNT_W'(1) && fifo_pop));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cfg_first  <= '0;
            cfg_count  <= '0;
            cfg_points <= '0;
            slot_rel   <= '0;
            point_cnt  <= '0;
            rd_address <= '0;
            rd_slot    <= '0;
            rd_point   <= '0;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rd_en <= issue;
            if (issue) begin
                rd_address <= slot_addr(slot_abs, point_cnt, cfg_points);
                rd_slot    <= slot_abs;
                rd_point   <= point_cnt;
                if (last_point) begin
                    point_cnt <= '0;
                    slot_rel  <= slot_rel + SLOT_W'(1);
                end else begin
                    point_cnt <= point_cnt + POINT_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_first  <= slot_first;
                            cfg_count  <= slot_count;
                            cfg_points <= points;
                            slot_rel   <= '0;
                            point_cnt  <= '0;
                            busy       <= 1'b1;
                            state      <= READ;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue && last_read) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leaves as the last beat is accepted so done lands on the next cycle.
                    if (drained) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag pipeline tracks each read until its data appears on ram_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_v <= '0;
            for (int i = 0; i < RAM_LAT; i++) begin
                pipe_slot[i]  <= '0;
                pipe_point[i] <= '0;
            end
        end else begin
            for (int i = RAM_LAT - 1; i > 0; i--) begin
                pipe_v[i]     <= pipe_v[i-1];
                pipe_slot[i]  <= pipe_slot[i-1];
                pipe_point[i] <= pipe_point[i-1];
            end
            pipe_v[0]     <= rd_en;
            pipe_slot[0]  <= rd_slot;
            pipe_point[0] <= rd_point;
        end
    end

    sum_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_D)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign {out_data, out_slot, out_point} = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_sum_readout.sv
// Directed bench for sum_readout with a 2-cycle RAM model and a beat scoreboard.
module tb_sum_readout;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  slot_first;
    logic [3:0]  slot_count;
    logic [10:0] points;
    logic [14:0] rd_address;
    logic        rd_en;
    logic [31:0] ram_q;
    logic [31:0] out_data;
    logic [3:0]  out_slot;
    logic [10:0] out_point;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        err;

    sum_readout dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .slot_first (slot_first),
        .slot_count (slot_count),
        .points     (points),
        .rd_address (rd_address),
        .rd_en      (rd_en),
        .ram_q      (ram_q),
        .out_data   (out_data),
        .out_slot   (out_slot),
        .out_point  (out_point),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish by 500000 ns");
        $fatal(1, "watchdog");
    end

    // RAM model: data for the address presented two cycles earlier
    function automatic logic [31:0] ram_word(input logic [14:0] a);
        return {1'b1, a, ~a, 1'b0};
    endfunction

    logic [31:0] q1;
    always @(posedge clk) begin
        q1    <= ram_word(rd_address);
        ram_q <= q1;
    end

    // scoreboard
    logic [46:0] exp_q[$];
    logic [14:0] exp_addr_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int n_rd, n_beats, n_done, n_err, n_busy, fifo_max;
    int first_rd_cyc, first_vld_cyc, first_beat_cyc, last_beat_cyc, done_cyc;
    logic [14:0] first_addr, last_addr;
    logic        hold_pending;
    logic [47:0] held_val;

    task automatic clear_stats();
        n_rd = 0; n_beats = 0; n_done = 0; n_err = 0; n_busy = 0; fifo_max = 0;
        first_rd_cyc = -1; first_vld_cyc = -1; first_beat_cyc = -1;
        last_beat_cyc = -1; done_cyc = -1;
        first_addr = '0; last_addr = '0;
        hold_pending = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            hold_pending = 1'b0;
        end else begin
            if (rd_en) begin
                if (n_rd == 0) begin
                    first_rd_cyc = cyc;
                    first_addr   = rd_address;
                end
                last_addr = rd_address;
                n_rd++;
                if (exp_addr_q.size() > 0) check("rd_addr", rd_address, exp_addr_q.pop_front());
            end
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (hold_pending) check("stall_hold", {out_valid, out_data, out_slot, out_point}, held_val);
            hold_pending = out_valid && !out_ready;
            held_val     = {out_valid, out_data, out_slot, out_point};
            if (out_valid && out_ready) begin
                n_beats++;
                if (first_beat_cyc < 0) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                if (exp_q.size() > 0) check("beat", {out_data, out_slot, out_point}, exp_q.pop_front());
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (err)  n_err++;
            if (busy) n_busy++;
            if (int'(dut.u_fifo.count) > fifo_max) fifo_max = int'(dut.u_fifo.count);
        end
    end

    // driver tasks
    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic start_run(input int first, input int cnt, input int pts, input bit load);
        int a;
        if (load) begin
            for (int s = 0; s < cnt; s++) begin
                for (int p = 0; p < pts; p++) begin
                    a = p + (first + s) * pts;
                    exp_addr_q.push_back(15'(a));
                    exp_q.push_back({ram_word(15'(a)), 4'(first + s), 11'(p)});
                end
            end
        end
        @(posedge clk); #1;
        start      = 1'b1;
        slot_first = 4'(first);
        slot_count = 4'(cnt);
        points     = 11'(pts);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int n0;
        int k;
        n0 = n_done;
        k  = 0;
        while (n_done == n0 && k < budget) begin
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            k++;
        end
        check("done_timeout", 64'(n_done == n0), 0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        start = 1'b0; slot_first = '0; slot_count = '0; points = '0;
        out_ready = 1'b1;
        clear_stats();
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_rd_address", rd_address, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);

        // 5 points in slot 0, sink always ready
        clear_stats();
        start_run(0, 1, 5, 1);
        wait_done(100, 0);
        check("t1_beats", n_beats, 5);
        check("t1_reads", n_rd, 5);
        check("t1_last_addr", last_addr, 4);
        check("t1_latency", first_vld_cyc - first_rd_cyc, 3);
        check("t1_throughput", last_beat_cyc - first_beat_cyc, 4);
        check("t1_done_after_last", done_cyc - last_beat_cyc, 1);
        check("t1_done_count", n_done, 1);
        check("t1_busy_after", busy, 0);
        check("t1_exp_left", exp_q.size(), 0);

        // largest legal run: last slot, 2047 points
        clear_stats();
        start_run(9, 1, 2047, 1);
        wait_done(3000, 0);
        check("t2_first_addr", first_addr, 18423);
        check("t2_last_addr", last_addr, 20469);
        check("t2_beats", n_beats, 2047);
        check("t2_throughput", last_beat_cyc - first_beat_cyc, 2046);
        check("t2_exp_left", exp_q.size(), 0);

        // three slots with a sink that stalls every other cycle
        clear_stats();
        start_run(2, 3, 3, 1);
        wait_done(200, 1);
        check("t3_first_addr", first_addr, 6);
        check("t3_last_addr", last_addr, 14);
        check("t3_beats", n_beats, 9);
        check("t3_fifo_le4", 64'(fifo_max <= 4), 1);
        check("t3_done_count", n_done, 1);
        check("t3_exp_left", exp_q.size(), 0);

        // invalid configs: slot range overflow, then zero points
        clear_stats();
        start_run(8, 3, 5, 0);
        repeat (8) @(posedge clk); #1;
        check("t4_err_pulses", n_err, 1);
        check("t4_busy", n_busy, 0);
        check("t4_reads", n_rd, 0);
        clear_stats();
        start_run(0, 1, 0, 0);
        repeat (8) @(posedge clk); #1;
        check("t4b_err_pulses", n_err, 1);
        check("t4b_busy", n_busy, 0);
        check("t4b_reads", n_rd, 0);

        // reset in the middle of a 100-point readout
        clear_stats();
        start_run(3, 2, 100, 1);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_rd_address", rd_address, 0);
        check("t5_rd_en", rd_en, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_out_data", {out_data, out_slot, out_point}, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_err", err, 0);
        @(posedge clk); #1 reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (5) @(posedge clk); #1;
        check("t5_no_done", n_done, 0);
        check("t5_idle_busy", busy, 0);
        clear_stats();
        start_run(3, 1, 100, 1);
        wait_done(300, 0);
        check("t5_restart_addr", first_addr, 300);
        check("t5_restart_beats", n_beats, 100);
        check("t5_restart_done", n_done, 1);
        check("t5_exp_left", exp_q.size(), 0);

        // start while busy is ignored
        clear_stats();
        start_run(1, 2, 5, 1);
        repeat (3) @(posedge clk);
        start_run(0, 1, 3, 0);
        wait_done(200, 0);
        check("t6_beats", n_beats, 10);
        check("t6_reads", n_rd, 10);
        check("t6_err", n_err, 0);
        check("t6_done", n_done, 1);
        check("t6_last_addr", last_addr, 14);
        check("t6_exp_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
